dcache_miss_unit: RTL and testbench

DCACHE_MISS_UNIT -- requirements
Module: dcache_miss_unit

---
 rtl/dcache_miss_unit.sv | 194 +++++++++++++++++++
 tb/tb_dcache_miss_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_unit.sv
// Data-cache miss handler: optional dirty-victim writeback, then a block refill, one word per beat.
// Optional feature macro: DCACHE_MISS_CRITICAL_WORD_FIRST_EN (refill starts at the missing word).
module dcache_miss_unit #(
  parameter int ADDR_BITS        = 8,
  parameter int DATA_BITS        = 8,
  parameter int CACHE_BLOCK_SIZE = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  miss_valid,
  output logic                                  miss_ready,
  input  logic [ADDR_BITS-1:0]                  miss_address,
  input  logic                                  miss_evict_valid,
  input  logic [ADDR_BITS-1:0]                  miss_evict_address,
  input  logic [CACHE_BLOCK_SIZE*DATA_BITS-1:0] miss_evict_data,
  output logic                                  fill_valid,
  output logic [ADDR_BITS-1:0]                  fill_address,
  output logic [CACHE_BLOCK_SIZE*DATA_BITS-1:0] fill_data,
  output logic                                  mem_read_valid,
  output logic [ADDR_BITS-1:0]                  mem_read_address,
  input  logic                                  mem_read_ready,
  input  logic [DATA_BITS-1:0]                  mem_read_data,
  output logic                                  mem_write_valid,
  output logic [ADDR_BITS-1:0]                  mem_write_address,
  output logic [DATA_BITS-1:0]                  mem_write_data,
  input  logic                                  mem_write_ready
);

  localparam int OFF_BITS   = $clog2(CACHE_BLOCK_SIZE);
  localparam int BLOCK_BITS = CACHE_BLOCK_SIZE * DATA_BITS;
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(CACHE_BLOCK_SIZE - 1);

`ifdef DCACHE_MISS_CRITICAL_WORD_FIRST_EN
  localparam bit CRIT_FIRST = 1'b1;
`else
  localparam bit CRIT_FIRST = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    FILL    = 3'd5
  } state_t;

  state_t                state_r;
  logic [OFF_BITS-1:0]   beat_r;
  logic [ADDR_BITS-1:0]  miss_addr_r;
  logic [ADDR_BITS-1:0]  evict_addr_r;
  logic [BLOCK_BITS-1:0] evict_data_r;
  logic [OFF_BITS-1:0]   rd_off_s;

  function automatic logic [ADDR_BITS-1:0] block_base(input logic [ADDR_BITS-1:0] a);
    block_base = a & ~ADDR_BITS'(CACHE_BLOCK_SIZE - 1);
  endfunction

  // Offset is OR-ed into a cleared field, so it can never carry into the tag/index bits.
  function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [ADDR_BITS-1:0] a,
                                                     input logic [OFF_BITS-1:0]  off);
    beat_addr = block_base(a) | ADDR_BITS'(off);
  endfunction

  function automatic logic [DATA_BITS-1:0] word_of(input logic [BLOCK_BITS-1:0] blk,
                                                   input logic [OFF_BITS-1:0]   idx);
    word_of = blk[idx*DATA_BITS +: DATA_BITS];
  endfunction

  function automatic logic [OFF_BITS-1:0] rd_start(input logic [OFF_BITS-1:0] miss_off);
    rd_start = CRIT_FIRST ? miss_off : {OFF_BITS{1'b0}};
  endfunction

  // Read offset wraps modulo the block size by natural truncation.
  assign rd_off_s = rd_start(miss_addr_r[OFF_BITS-1:0]) + beat_r;

  // Miss-handling state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= IDLE;
      beat_r            <= {OFF_BITS{1'b0}};
      miss_addr_r       <= {ADDR_BITS{1'b0}};
      evict_addr_r      <= {ADDR_BITS{1'b0}};
      evict_data_r      <= {BLOCK_BITS{1'b0}};
      miss_ready        <= 1'b1;
      fill_valid        <= 1'b0;
      fill_address      <= {ADDR_BITS{1'b0}};
      fill_data         <= {BLOCK_BITS{1'b0}};
      mem_read_valid    <= 1'b0;
      mem_read_address  <= {ADDR_BITS{1'b0}};
      mem_write_valid   <= 1'b0;
      mem_write_address <= {ADDR_BITS{1'b0}};
      mem_write_data    <= {DATA_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          fill_valid <= 1'b0;
          if (miss_valid) begin
            miss_ready   <= 1'b0;
            miss_addr_r  <= miss_address;
            evict_addr_r <= miss_evict_address;
            evict_data_r <= miss_evict_data;
            beat_r       <= {OFF_BITS{1'b0}};
            if (miss_evict_valid) begin
              state_r           <= WB_REQ;
              mem_write_valid   <= 1'b1;
              mem_write_address <= beat_addr(miss_evict_address, {OFF_BITS{1'b0}});
              mem_write_data    <= word_of(miss_evict_data, {OFF_BITS{1'b0}});
            end else begin
              state_r          <= RD_REQ;
              mem_read_valid   <= 1'b1;
              mem_read_address <= beat_addr(miss_address, rd_start(miss_address[OFF_BITS-1:0]));
            end
          end else begin
            miss_ready <= 1'b1;
          end
        end

        WB_REQ: begin
          if (mem_write_ready) begin
            mem_write_valid <= 1'b0;
            state_r         <= WB_WAIT;
          end else begin
            mem_write_valid <= 1'b1;
          end
        end

        // The controller must drop its acknowledge before the next beat is offered.
        WB_WAIT: begin
          if (!mem_write_ready) begin
            if (beat_r == LAST_BEAT) begin
              beat_r           <= {OFF_BITS{1'b0}};
              state_r          <= RD_REQ;
              mem_read_valid   <= 1'b1;
              mem_read_address <= beat_addr(miss_addr_r, rd_start(miss_addr_r[OFF_BITS-1:0]));
            end else begin
              beat_r            <= beat_r + OFF_BITS'(1);
              state_r           <= WB_REQ;
              mem_write_valid   <= 1'b1;
              mem_write_address <= beat_addr(evict_addr_r, beat_r + OFF_BITS'(1));
              mem_write_data    <= word_of(evict_data_r, beat_r + OFF_BITS'(1));
            end
          end else begin
            state_r <= WB_WAIT;
          end
        end

        RD_REQ: begin
          if (mem_read_ready) begin
            fill_data[rd_off_s*DATA_BITS +: DATA_BITS] <= mem_read_data;
            mem_read_valid <= 1'b0;
            state_r        <= RD_WAIT;
          end else begin
            mem_read_valid <= 1'b1;
          end
        end

        RD_WAIT: begin
          if (!mem_read_ready) begin
            if (beat_r == LAST_BEAT) begin
              beat_r       <= {OFF_BITS{1'b0}};
              state_r      <= FILL;
              fill_valid   <= 1'b1;
              fill_address <= block_base(miss_addr_r);
            end else begin
              beat_r           <= beat_r + OFF_BITS'(1);
              state_r          <= RD_REQ;
              mem_read_valid   <= 1'b1;
              mem_read_address <= beat_addr(miss_addr_r, rd_off_s + OFF_BITS'(1));
            end
          end else begin
            state_r <= RD_WAIT;
          end
        end

        FILL: begin
          fill_valid <= 1'b0;
          miss_ready <= 1'b1;
          state_r    <= IDLE;
        end

        default: begin
          state_r         <= IDLE;
          beat_r          <= {OFF_BITS{1'b0}};
          miss_ready      <= 1'b1;
          fill_valid      <= 1'b0;
          mem_read_valid  <= 1'b0;
          mem_write_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_unit.sv
// Self-checking bench for dcache_miss_unit: table-driven misses, a responsive memory model
// with scoreboard queues, plus back-to-back and reset-mid-writeback sequences.
`timescale 1ns/1ps
module tb_dcache_miss_unit;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic reset;
  logic miss_valid, miss_ready;
  logic [AB-1:0] miss_address;
  logic miss_evict_valid;
  logic [AB-1:0] miss_evict_address;
  logic [N*DB-1:0] miss_evict_data;
  logic fill_valid;
  logic [AB-1:0] fill_address;
  logic [N*DB-1:0] fill_data;
  logic mem_read_valid;
  logic [AB-1:0] mem_read_address;
  logic mem_read_ready;
  logic [DB-1:0] mem_read_data;
  logic mem_write_valid;
  logic [AB-1:0] mem_write_address;
  logic [DB-1:0] mem_write_data;
  logic mem_write_ready;

  dcache_miss_unit #(.ADDR_BITS(AB), .DATA_BITS(DB), .CACHE_BLOCK_SIZE(N)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_address(miss_address),
    .miss_evict_valid(miss_evict_valid), .miss_evict_address(miss_evict_address),
    .miss_evict_data(miss_evict_data),
    .fill_valid(fill_valid), .fill_address(fill_address), .fill_data(fill_data),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        ev;
    logic [7:0]  ev_addr;
    logic [31:0] ev_data;
    int          delay;
    logic [7:0]  exp_fill_addr;
    logic [31:0] exp_fill_data;
  } vec_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; int lat; } fill_t;

  logic [7:0] exp_rd_q[$];
  wr_t        exp_wr_q[$];
  fill_t      exp_fill_q[$];
  logic [7:0] mem [256];
  vec_t       vecs [4];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0, mem_delay = 0;
  int fill_count = 0, valid_seen = 0;
  bit busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_expect(input vec_t v);
    wr_t w;
    fill_t f;
    int start;
    if (v.ev) begin
      for (int i = 0; i < N; i++) begin
        w.addr = {v.ev_addr[7:2], 2'(i)};
        w.data = v.ev_data[i*8 +: 8];
        exp_wr_q.push_back(w);
      end
    end
`ifdef DCACHE_MISS_CRITICAL_WORD_FIRST_EN
    start = int'(v.addr[1:0]);
`else
    start = 0;
`endif
    for (int i = 0; i < N; i++) exp_rd_q.push_back({v.addr[7:2], 2'((start + i) % N)});
    f.addr = v.exp_fill_addr;
    f.data = v.exp_fill_data;
    f.lat  = (v.delay == 0) ? (v.ev ? 4*N+1 : 2*N+1) : -1;
    exp_fill_q.push_back(f);
  endtask

  task automatic drive(input vec_t v);
    miss_valid         = 1'b1;
    miss_address       = v.addr;
    miss_evict_valid   = v.ev;
    miss_evict_address = v.ev_addr;
    miss_evict_data    = v.ev_data;
  endtask

  task automatic scramble();
    miss_address       = 8'($urandom);
    miss_evict_valid   = 1'($urandom);
    miss_evict_address = 8'($urandom);
    miss_evict_data    = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    while (miss_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    check({tag, "_idle"}, miss_ready, 1);
  endtask

  task automatic wait_fill(input string tag);
    int w = 0;
    while (exp_fill_q.size() != 0 && w < 400) begin @(negedge clk); w++; end
    check({tag, "_fill_done"}, exp_fill_q.size(), 0);
    exp_fill_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
  endtask

  task automatic run_miss(input vec_t v, input string tag);
    wait_idle(tag);
    mem_delay = v.delay;
    push_expect(v);
    drive(v);
    acc_cyc = cyc;
    @(negedge clk);
    busy = 1'b1;
    miss_valid = 1'b0;
    scramble();
    wait_fill(tag);
    repeat (3) @(negedge clk);
    check({tag, "_hold_addr"}, fill_address, v.exp_fill_addr);
    check({tag, "_hold_data"}, fill_data, v.exp_fill_data);
  endtask

  // Memory controller model: acks each request after mem_delay cycles, checks against scoreboard.
  initial begin
    int rd_cnt = 0, wr_cnt = 0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_read_valid === 1'b1 || mem_write_valid === 1'b1) begin
        valid_seen++;
        check("no_dual_valid", {mem_read_valid, mem_write_valid} == 2'b11, 0);
      end
      if (mem_read_valid === 1'b1 && !mem_read_ready) begin
        if (rd_cnt >= mem_delay) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem[mem_read_address];
          check("wb_before_read", exp_wr_q.size(), 0);
          if (exp_rd_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_read: got addr 0x%0h expected none", mem_read_address);
          end else check("read_addr", mem_read_address, exp_rd_q.pop_front());
        end else rd_cnt++;
      end else begin
        mem_read_ready = 1'b0;
        mem_read_data  = 8'($urandom);
        rd_cnt = 0;
      end
      if (mem_write_valid === 1'b1 && !mem_write_ready) begin
        if (wr_cnt >= mem_delay) begin
          wr_t e;
          mem_write_ready = 1'b1;
          if (exp_wr_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: got addr 0x%0h expected none", mem_write_address);
          end else begin
            e = exp_wr_q.pop_front();
            check("write_addr", mem_write_address, e.addr);
            check("write_data", mem_write_data, e.data);
          end
        end else wr_cnt++;
      end else begin
        mem_write_ready = 1'b0;
        wr_cnt = 0;
      end
    end
  end

  // Fill monitor: pops expected fills, checks pulse width, latency and miss_ready while busy.
  initial begin
    bit prev_fill = 1'b0;
    fill_t e;
    forever begin
      @(negedge clk);
      if (fill_valid === 1'b1) begin
        fill_count++;
        check("fill_single_cycle", prev_fill, 0);
        check("fill_ready_low", miss_ready, 0);
        if (exp_fill_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_fill: got addr 0x%0h expected none", fill_address);
        end else begin
          e = exp_fill_q.pop_front();
          check("fill_addr", fill_address, e.addr);
          check("fill_data", fill_data, e.data);
          if (e.lat >= 0) check("fill_latency", cyc - acc_cyc, e.lat);
        end
        busy = 1'b0;
      end else if (busy && miss_ready === 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL busy_ready: got miss_ready 1 expected 0");
      end
      prev_fill = fill_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb, vr;
    int w, fc, vc;
    reset = 1'b1; miss_valid = 1'b0; miss_address = 8'h00; miss_evict_valid = 1'b0;
    miss_evict_address = 8'h00; miss_evict_data = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;

    vecs[0] = '{8'h13, 1'b0, 8'h00, 32'h00000000, 0, 8'h10, 32'hDDCCBBAA};
    vecs[1] = '{8'h08, 1'b1, 8'h40, 32'h44332211, 0, 8'h08, 32'hAEAFACAD};
    vecs[2] = '{8'hFE, 1'b0, 8'h00, 32'h00000000, 2, 8'hFC, 32'h5A5B5859};
    vecs[3] = '{8'h31, 1'b1, 8'hF0, 32'hDEADBEEF, 2, 8'h30, 32'h96979495};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_miss_ready", miss_ready, 1);
    check("rst_rd_valid", mem_read_valid, 0);
    check("rst_wr_valid", mem_write_valid, 0);
    check("rst_fill_valid", fill_valid, 0);
    check("rst_fill_data", fill_data, 0);
    check("rst_fill_addr", fill_address, 0);
    check("rst_wr_addr_data", {mem_write_address, mem_write_data, mem_read_address}, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_miss(vecs[i], $sformatf("vec%0d", i));

    // Second miss held pending across the first fill.
    wait_idle("b2b");
    mem_delay = 0;
    va = vecs[0];
    vb = '{8'h25, 1'b0, 8'h00, 32'h00000000, 0, 8'h24, 32'h82838081};
    push_expect(va);
    drive(va);
    acc_cyc = cyc;
    @(negedge clk);
    busy = 1'b1;
    push_expect(vb);
    drive(vb);
    w = 0;
    while (fill_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    check("b2b_first_fill_seen", fill_valid, 1);
    check("b2b_ready_during_fill", miss_ready, 0);
    @(negedge clk);
    check("b2b_ready_after_fill", miss_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    busy = 1'b1;
    check("b2b_second_accepted", miss_ready, 0);
    miss_valid = 1'b0;
    wait_fill("b2b_second");

    // Reset while the first writeback beat is stalled.
    wait_idle("rstwb");
    mem_delay = 1000;
    vr = '{8'h50, 1'b1, 8'h80, 32'h01020304, 1000, 8'h50, 32'h0};
    drive(vr);
    @(negedge clk);
    miss_valid = 1'b0;
    check("wbreq_write_valid", mem_write_valid, 1);
    check("wbreq_ready_low", miss_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rstwb_write_valid", mem_write_valid, 0);
    check("rstwb_miss_ready", miss_ready, 1);
    check("rstwb_fill_data", fill_data, 0);
    check("rstwb_wr_addr", mem_write_address, 0);
    reset = 1'b0;
    fc = fill_count;
    vc = valid_seen;
    repeat (30) @(negedge clk);
    check("rstwb_no_fill", fill_count - fc, 0);
    check("rstwb_no_request", valid_seen - vc, 0);
    mem_delay = 0;

    run_miss(vecs[1], "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
